// File: rtl/pipeif_fetch.sv
// pipeif_fetch: MIPS IF stage with IF/ID register, req/ack instruction fetch and delayed-branch redirect
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_dpc4, r_inst, r_hold, r_pend_pc;
  logic        r_dvalid, r_pend_v;
  logic [31:0] w_pc4, w_target, w_word;
  logic        w_ack, w_adv, w_bubble, w_capture, w_redirect;
  assign w_ack      = (r_state == WAIT) & imem_ack;
  assign w_adv      = (w_ack | (r_state == HOLD)) & wpcir;
  assign w_bubble   = (r_state == WAIT) & ~imem_ack & wpcir;
  assign w_capture  = w_ack & ~wpcir;
  assign w_redirect = r_dvalid & wpcir & (pcsource != 2'b00);
  assign w_pc4      = r_pc + 32'd4;
  assign w_target   = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? da : jpc;
  assign w_word     = (r_state == HOLD) ? r_hold : imem_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = WAIT;
      WAIT:    w_next = w_capture ? HOLD : WAIT;
      HOLD:    w_next = wpcir ? WAIT : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // A pending target outranks a fresh redirect; both cannot coexist since decode holds a bubble after capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_dpc4    <= '0;
      r_inst    <= '0;
      r_dvalid  <= 1'b0;
      r_hold    <= '0;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      if (w_adv) begin
        r_dpc4   <= w_pc4;
        r_inst   <= w_word;
        r_dvalid <= 1'b1;
        r_pc     <= r_pend_v ? r_pend_pc : (w_redirect ? w_target : w_pc4);
        r_pend_v <= 1'b0;
      end else if (w_bubble) begin
        r_inst   <= '0;
        r_dvalid <= 1'b0;
        if (w_redirect) begin
          r_pend_v  <= 1'b1;
          r_pend_pc <= w_target;
        end
      end
      if (w_capture) r_hold <= imem_rdata;
    end
  end
  assign imem_req  = (r_state == WAIT);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dpc4      = r_dpc4;
  assign inst      = r_inst;
  assign dvalid    = r_dvalid;
endmodule

// File: tb/tb_pipeif_fetch.sv
// tb_pipeif_fetch: directed vector table, corner sequences and randomized run against a fetch-stream model
module tb_pipeif_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic        clock = 1'b0, reset = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, jpc = '0, da = '0, imem_rdata = '0;
  logic        wpcir = 1'b0, imem_ack = 1'b0;
  logic        imem_req, dvalid;
  logic [31:0] imem_addr, pc, dpc4, inst;
  int checks = 0, errors = 0;

  pipeif_fetch #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .da(da),
    .wpcir(wpcir), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h8C00_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wp, input logic ack, input logic [1:0] ps, input logic [31:0] tgt);
    wpcir = wp; imem_ack = ack; pcsource = ps;
    bpc = tgt; jpc = tgt; da = tgt;
    imem_rdata = mem(imem_addr);
  endtask

  typedef struct {
    logic wp; logic ack; logic [1:0] ps; logic [31:0] tgt;
    logic req; logic [31:0] pc; logic [31:0] dpc4; logic dv;
  } vec_t;
  vec_t vec [17];

  function automatic vec_t mk(input logic wp, input logic ack, input logic [1:0] ps, input logic [31:0] tgt,
                              input logic req, input logic [31:0] p, input logic [31:0] d4, input logic dv);
    vec_t v;
    v.wp = wp; v.ack = ack; v.ps = ps; v.tgt = tgt; v.req = req; v.pc = p; v.dpc4 = d4; v.dv = dv;
    return v;
  endfunction

  // Model: fetch stream indexed by fetch number; a branch accepted from ID at index k
  // forces the address of fetch k+2 (the one after its delay slot).
  logic [31:0] m_last, m_av_addr, m_dpc4, m_inst;
  logic [31:0] m_redir [int];
  int  m_n, m_av_idx, m_idx;
  bit  m_started, m_av, m_dv;

  function automatic logic [31:0] m_exp_addr();
    if (m_n == 0) return RPC;
    if (m_redir.exists(m_n)) return m_redir[m_n];
    return m_last + 32'd4;
  endfunction

  task automatic m_reset();
    m_n = 0; m_started = 0; m_av = 0; m_dv = 0; m_idx = 0;
    m_dpc4 = '0; m_inst = '0; m_last = '0; m_av_addr = '0; m_av_idx = 0;
    m_redir.delete();
  endtask

  task automatic m_step();
    logic [31:0] a;
    if (m_dv && wpcir && pcsource != 2'b00)
      m_redir[m_idx + 2] = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? da : jpc;
    if (m_started && !m_av && imem_ack) begin
      a = m_exp_addr();
      m_av = 1; m_av_addr = a; m_av_idx = m_n; m_last = a; m_n++;
    end
    if (wpcir) begin
      if (m_av) begin
        m_dpc4 = m_av_addr + 32'd4; m_inst = mem(m_av_addr); m_dv = 1; m_idx = m_av_idx; m_av = 0;
      end else begin
        m_inst = '0; m_dv = 0;
      end
    end
    m_started = 1;
  endtask

  initial begin
    vec[0]  = mk(1, 0, 0, 0,             0, 32'h100,    32'h0,      0);
    vec[1]  = mk(1, 1, 0, 0,             1, 32'h100,    32'h0,      0);
    vec[2]  = mk(1, 1, 0, 0,             1, 32'h104,    32'h104,    1);
    vec[3]  = mk(1, 1, 1, 32'h200,       1, 32'h108,    32'h108,    1);
    vec[4]  = mk(1, 1, 0, 0,             1, 32'h200,    32'h10C,    1);
    vec[5]  = mk(1, 1, 0, 0,             1, 32'h204,    32'h204,    1);
    vec[6]  = mk(1, 0, 1, 32'h300,       1, 32'h208,    32'h208,    1);
    vec[7]  = mk(1, 0, 1, 32'h300,       1, 32'h208,    32'h208,    0);
    vec[8]  = mk(1, 1, 0, 0,             1, 32'h208,    32'h208,    0);
    vec[9]  = mk(0, 1, 0, 0,             1, 32'h300,    32'h20C,    1);
    vec[10] = mk(0, 1, 0, 0,             0, 32'h300,    32'h20C,    1);
    vec[11] = mk(1, 0, 0, 0,             0, 32'h300,    32'h20C,    1);
    vec[12] = mk(1, 1, 2, 32'h3000,      1, 32'h304,    32'h304,    1);
    vec[13] = mk(1, 1, 0, 0,             1, 32'h3000,   32'h308,    1);
    vec[14] = mk(1, 1, 3, 32'h0040_0000, 1, 32'h3004,   32'h3004,   1);
    vec[15] = mk(1, 1, 0, 0,             1, 32'h400000, 32'h3008,   1);
    vec[16] = mk(0, 0, 0, 0,             1, 32'h400004, 32'h400004, 1);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("vec%0d.req", i), {31'd0, imem_req}, {31'd0, vec[i].req});
      chk($sformatf("vec%0d.pc", i), pc, vec[i].pc);
      if (vec[i].req) chk($sformatf("vec%0d.addr", i), imem_addr, vec[i].pc);
      chk($sformatf("vec%0d.dpc4", i), dpc4, vec[i].dpc4);
      chk($sformatf("vec%0d.dvalid", i), {31'd0, dvalid}, {31'd0, vec[i].dv});
      chk($sformatf("vec%0d.inst", i), inst, vec[i].dv ? mem(vec[i].dpc4 - 32'd4) : 32'd0);
      drive(vec[i].wp, vec[i].ack, vec[i].ps, vec[i].tgt);
      @(negedge clock);
    end

    drive(1, 1, 3, 32'hFFFF_FFF8);
    @(negedge clock);
    chk("jmp_hi.pc", pc, 32'hFFFF_FFF8);
    chk("jmp_hi.dpc4", dpc4, 32'h0040_0008);
    drive(1, 1, 0, 0);
    @(negedge clock);
    chk("pre_wrap.pc", pc, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0);
    @(negedge clock);
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.dpc4", dpc4, 32'h0);
    chk("wrap.inst", inst, mem(32'hFFFF_FFFC));
    chk("wrap.req", {31'd0, imem_req}, 32'd1);

    reset = 1'b1;
    drive(1, 1, 0, 0);
    @(negedge clock);
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.pc", pc, RPC);
    chk("rst.dpc4", dpc4, 32'h0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.dvalid", {31'd0, dvalid}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst.req", {31'd0, imem_req}, 32'd1);
    chk("post_rst.addr", imem_addr, RPC);
    chk("post_rst.dvalid", {31'd0, dvalid}, 32'd0);

    reset = 1'b1;
    m_reset();
    @(negedge clock);
    for (int c = 0; c < 4000; c++) begin
      chk("rnd.req", {31'd0, imem_req}, {31'd0, m_started && !m_av});
      if (m_started && !m_av) chk("rnd.addr", imem_addr, m_exp_addr());
      chk("rnd.dpc4", dpc4, m_dpc4);
      chk("rnd.inst", inst, m_inst);
      chk("rnd.dvalid", {31'd0, dvalid}, {31'd0, m_dv});
      reset = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            {$urandom, 2'b00} >> 2 << 2);
      bpc = {bpc[31:2] ^ 30'h155, 2'b00};
      da  = {da[31:2] + 30'h40, 2'b00};
      if (reset) m_reset();
      else m_step();
      @(negedge clock);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
